// File: rtl/med_blocos_avg_if.sv
// Frame control, source-memory port and result-read port of the block-average downscaler.
// The downscaler connects as the slave side; the frame controller, source memory and consumer form the master side.
interface med_blocos_avg_if;
    logic        start;
    logic [14:0] in_addr;
    logic [7:0]  in_data;
    logic        busy;
    logic        done;
    logic [10:0] out_rd_addr;
    logic [7:0]  out_rd_data;

    modport master (
        output start, in_data, out_rd_addr,
        input  in_addr, busy, done, out_rd_data
    );

    modport slave (
        input  start, in_data, out_rd_addr,
        output in_addr, busy, done, out_rd_data
    );
endinterface

// File: rtl/med_blocos_avg.sv
// Downscales a W_IN x H_IN 8-bit image by averaging FACTOR x FACTOR blocks into memoria_saida.
// Source pixels come from an external synchronous memory with one cycle of read latency.
module med_blocos_avg #(
    parameter int unsigned W_IN   = 160,
    parameter int unsigned H_IN   = 120,
    parameter int unsigned FACTOR = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    med_blocos_avg_if.slave bus
);
    localparam int unsigned W_OUT = W_IN / FACTOR;
    localparam int unsigned H_OUT = H_IN / FACTOR;
    localparam int unsigned N_OUT = W_OUT * H_OUT;
    localparam int unsigned SHIFT = $clog2(FACTOR * FACTOR);
    localparam int unsigned ACC_W = 8 + SHIFT;
    localparam int unsigned FW    = (FACTOR > 1) ? $clog2(FACTOR) : 1;
    localparam int unsigned BXW   = (W_OUT > 1) ? $clog2(W_OUT) : 1;
    localparam int unsigned BYW   = (H_OUT > 1) ? $clog2(H_OUT) : 1;

    localparam logic [FW-1:0]  F_LAST  = FW'(FACTOR - 1);
    localparam logic [BXW-1:0] BX_LAST = BXW'(W_OUT - 1);
    localparam logic [BYW-1:0] BY_LAST = BYW'(H_OUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    i_q, i_d, j_q, j_d;
    logic [BXW-1:0]   bx_q, bx_d;
    logic [BYW-1:0]   by_q, by_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [14:0]      in_addr_q, in_addr_d;
    logic             done_q, done_d;
    logic [7:0]       rd_data_q;

    logic [ACC_W-1:0] sum;
    logic             wr_en;
    logic [10:0]      wr_idx;
    logic [7:0]       wr_data;
    logic             busy;

    logic [7:0] memoria_saida [0:N_OUT-1];

    function automatic logic [14:0] pix_addr(
        input logic [BXW-1:0] bx,
        input logic [BYW-1:0] by,
        input logic [FW-1:0]  i,
        input logic [FW-1:0]  j
    );
        int unsigned a;
        a = (32'(by) * FACTOR + 32'(j)) * W_IN + 32'(bx) * FACTOR + 32'(i);
        return 15'(a);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            acc_q     <= '0;
            in_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            acc_q     <= acc_d;
            in_addr_q <= in_addr_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        bx_d      = bx_q;
        by_d      = by_q;
        acc_d     = acc_q;
        in_addr_d = in_addr_q;
        done_d    = done_q;
        wr_en     = 1'b0;
        busy      = 1'b0;
        sum       = acc_q + ACC_W'(bus.in_data);
        wr_data   = 8'(sum >> SHIFT);
        wr_idx    = 11'(32'(by_q) * W_OUT + 32'(bx_q));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    i_d       = '0;
                    j_d       = '0;
                    bx_d      = '0;
                    by_d      = '0;
                    acc_d     = '0;
                    in_addr_d = '0;
                    done_d    = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                // in_data lags in_addr by one cycle, so the first address of a block contributes nothing yet
                if (i_q != '0 || j_q != '0)
                    acc_d = sum;
                if (i_q == F_LAST) begin
                    i_d = '0;
                    j_d = j_q + 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
                if (i_q == F_LAST && j_q == F_LAST) begin
                    j_d     = '0;
                    state_d = WRITE;
                end else begin
                    in_addr_d = pix_addr(bx_q, by_q, i_d, j_d);
                end
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                acc_d = '0;
                if (bx_q == BX_LAST) begin
                    bx_d = '0;
                    by_d = by_q + 1'b1;
                end else begin
                    bx_d = bx_q + 1'b1;
                end
                if (bx_q == BX_LAST && by_q == BY_LAST) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    in_addr_d = pix_addr(bx_d, by_d, '0, '0);
                    state_d   = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result memory has no reset: contents survive resets and aborted frames.
    always_ff @(posedge clk) begin
        if (wr_en)
            memoria_saida[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_q <= '0;
        else if (32'(bus.out_rd_addr) < N_OUT)
            rd_data_q <= memoria_saida[bus.out_rd_addr];
        else
            rd_data_q <= '0;
    end

    assign bus.in_addr     = in_addr_q;
    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.out_rd_data = rd_data_q;
endmodule

// File: tb/tb_med_blocos_avg.sv
// Bench for med_blocos_avg: composite-pattern frame, aborted frame, and a random frame,
// each compared against a block-averaging reference model.
module tb_med_blocos_avg;
    localparam int unsigned W  = 160;
    localparam int unsigned H  = 120;
    localparam int unsigned F  = 4;
    localparam int unsigned WO = W / F;
    localparam int unsigned HO = H / F;
    localparam int unsigned NO = WO * HO;

    localparam int unsigned K_TRUNC   = 0;
    localparam int unsigned K_SAT     = 1;
    localparam int unsigned K_CHK     = 2;
    localparam int unsigned K_CONST   = 3;
    localparam int unsigned K_RAMP    = 4;
    localparam int unsigned K_ONEHOT  = 5;
    localparam int unsigned K_NEARONE = 6;
    localparam int unsigned K_FLAT10  = 7;
    localparam int unsigned K_ROWBG   = 8;

    typedef struct {
        int unsigned blk;
        int unsigned kind;
        logic [7:0]  exp;
    } vec_t;

    logic clk;
    logic rst_n;
    med_blocos_avg_if bus ();

    med_blocos_avg #(.W_IN(W), .H_IN(H), .FACTOR(F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  img      [0:W*H-1];
    logic [7:0]  exp_cur  [0:NO-1];
    logic [7:0]  exp_prev [0:NO-1];
    vec_t        vecs     [12];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned c0       = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External source memory: data follows the address by one clock.
    always @(posedge clk) begin
        if (32'(bus.in_addr) < W * H)
            bus.in_data <= img[bus.in_addr];
        else
            bus.in_data <= 8'h00;
    end

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic build_model();
        for (int unsigned r = 0; r < HO; r++) begin
            for (int unsigned c = 0; c < WO; c++) begin
                int unsigned s = 0;
                for (int unsigned y = r * F; y < r * F + F; y++)
                    for (int unsigned x = c * F; x < c * F + F; x++)
                        s += 32'(img[y * W + x]);
                exp_cur[r * WO + c] = 8'(s / (F * F));
            end
        end
    endtask

    task automatic fill_block(input int unsigned blk, input int unsigned kind);
        int unsigned bx = blk % WO;
        int unsigned by = blk / WO;
        for (int unsigned j = 0; j < F; j++) begin
            for (int unsigned i = 0; i < F; i++) begin
                int unsigned x = bx * F + i;
                int unsigned y = by * F + j;
                int unsigned n = j * F + i;
                logic [7:0] v;
                case (kind)
                    K_TRUNC:   v = (n == 5) ? 8'h0F : 8'h00;
                    K_SAT:     v = 8'hFF;
                    K_CHK:     v = (((x + y) % 2) == 1) ? 8'hFF : 8'h00;
                    K_CONST:   v = 8'h80;
                    K_RAMP:    v = 8'(n);
                    K_ONEHOT:  v = (n == 0) ? 8'hFF : 8'h00;
                    K_NEARONE: v = (n == 9) ? 8'h00 : 8'h01;
                    K_FLAT10:  v = 8'h10;
                    default:   v = 8'(y);
                endcase
                img[y * W + x] = v;
            end
        end
    endtask

    task automatic randomize_img();
        for (int unsigned p = 0; p < W * H; p++)
            img[p] = 8'($urandom_range(0, 255));
    endtask

    task automatic rd(input int unsigned idx, output logic [7:0] v);
        bus.out_rd_addr = 11'(idx);
        @(posedge clk);
        #1;
        v = bus.out_rd_data;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        c0 = cyc;
    endtask

    // Entries below split must hold this frame's model; the rest must still hold exp_prev.
    task automatic compare_mem(input string name, input int unsigned split);
        int unsigned bad = 0;
        for (int unsigned k = 0; k < NO; k++) begin
            logic [7:0] want;
            want = (k < split) ? exp_cur[k] : exp_prev[k];
            if (dut.memoria_saida[k] !== want)
                bad++;
        end
        check(name, bad, 0);
    endtask

    // done must first appear after the 20400th edge following the start edge (cycle 20401).
    task automatic wait_done(input string name);
        bit          seen      = 1'b0;
        bit          prev_busy = 1'b1;
        int unsigned guard     = 0;
        while (!seen && guard < 25000) begin
            @(negedge clk);
            guard++;
            if (bus.done)
                seen = 1'b1;
            else
                prev_busy = bus.busy;
        end
        check({name, "_done_seen"}, 32'(seen), 1);
        check({name, "_done_latency"}, cyc - c0, NO * (F * F + 1));
        check({name, "_busy_at_done"}, 32'(bus.busy), 0);
        check({name, "_busy_before_done"}, 32'(prev_busy), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;

        vecs[0]  = '{0,    K_TRUNC,   8'h00};
        vecs[1]  = '{1,    K_SAT,     8'hFF};
        vecs[2]  = '{2,    K_CHK,     8'h7F};
        vecs[3]  = '{45,   K_CONST,   8'h80};
        vecs[4]  = '{80,   K_RAMP,    8'h07};
        vecs[5]  = '{639,  K_ONEHOT,  8'h0F};
        vecs[6]  = '{1000, K_NEARONE, 8'h00};
        vecs[7]  = '{1198, K_FLAT10,  8'h10};
        vecs[8]  = '{3,    K_ROWBG,   8'h01};
        vecs[9]  = '{40,   K_ROWBG,   8'h05};
        vecs[10] = '{600,  K_ROWBG,   8'h3D};
        vecs[11] = '{1199, K_ROWBG,   8'h75};

        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.out_rd_addr = '0;
        #12;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_in_addr", 32'(bus.in_addr), 0);
        check("rst_rd_data", 32'(bus.out_rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);

        // Frame 1: row-index background with special blocks from the table.
        for (int unsigned y = 0; y < H; y++)
            for (int unsigned x = 0; x < W; x++)
                img[y * W + x] = 8'(y);
        for (int unsigned t = 0; t < 12; t++)
            if (vecs[t].kind != K_ROWBG)
                fill_block(vecs[t].blk, vecs[t].kind);
        build_model();

        pulse_start();
        check("f1_busy_rise", 32'(bus.busy), 1);
        check("f1_first_addr", 32'(bus.in_addr), 0);
        @(posedge clk); #1;
        check("f1_addr_1", 32'(bus.in_addr), 1);
        repeat (3) @(posedge clk); #1;
        check("f1_addr_row1", 32'(bus.in_addr), W);
        repeat (12) @(posedge clk); #1;
        check("f1_addr_hold_write", 32'(bus.in_addr), 3 * W + 3);
        check("f1_busy_write", 32'(bus.busy), 1);
        @(posedge clk); #1;
        check("f1_addr_blk1", 32'(bus.in_addr), 4);
        repeat (17) @(posedge clk); #1;
        rd(1, v);
        check("f1_blk1_read_latency", 32'(v), 32'hFF);

        repeat (1000) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("f1_busy_after_restart_pulse", 32'(bus.busy), 1);
        wait_done("f1");
        repeat (3) @(negedge clk);
        check("f1_done_held", 32'(bus.done), 1);
        check("f1_idle_busy", 32'(bus.busy), 0);

        for (int unsigned t = 0; t < 12; t++) begin
            rd(vecs[t].blk, v);
            check($sformatf("vec%0d_blk%0d", t, vecs[t].blk), 32'(v), 32'(vecs[t].exp));
        end
        compare_mem("f1_all_entries", NO);

        // Frame 2: random image, aborted by reset after 500 cycles.
        exp_prev = exp_cur;
        randomize_img();
        build_model();
        pulse_start();
        check("f2_done_cleared", 32'(bus.done), 0);
        check("f2_busy", 32'(bus.busy), 1);
        repeat (500) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_in_addr", 32'(bus.in_addr), 0);
        check("abort_rd_data", 32'(bus.out_rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_stays_idle", 32'(bus.busy), 0);
        check("abort_addr_held", 32'(bus.in_addr), 0);
        compare_mem("abort_partial_entries", 29);
        rd(28, v);
        check("abort_blk28", 32'(v), 32'(exp_cur[28]));
        rd(29, v);
        check("abort_blk29_old", 32'(v), 32'(exp_prev[29]));

        // Frame 3: random image, full overwrite.
        randomize_img();
        build_model();
        pulse_start();
        check("f3_busy", 32'(bus.busy), 1);
        wait_done("f3");
        compare_mem("f3_all_entries", NO);
        for (int unsigned t = 0; t < 4; t++) begin
            int unsigned k = $urandom_range(0, NO - 1);
            rd(k, v);
            check($sformatf("f3_rand_read_%0d", k), 32'(v), 32'(exp_cur[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/med_blocos_avg.md
# med_blocos_avg

Block-average image downscaler (module `med_blocos_avg`). It reads a 160×120 8-bit grayscale image from an external synchronous memory. It averages each non-overlapping 4×4 block and stores the resulting 40×30 image in an internal output memory named `memoria_saida`, stored row-major. It sits between the frame source memory and the downstream consumer, which reads results through a read port or by hierarchical access to `memoria_saida[0..1199]`.

## Interface
- `W_IN`, 160: input image width in pixels.
- `H_IN`, 120: input image height in pixels.
- `FACTOR`, 4: block edge length; must be a power of 2. Output is `W_IN/FACTOR` × `H_IN/FACTOR`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to process a frame; ignored while `busy`.
- `in_addr`  out  15  input pixel address, row-major: `y*W_IN + x`.
- `in_data`  in  8  input pixel, valid one cycle after `in_addr` is presented.
- `busy`  out  1  high while a frame is being processed.
- `done`  out  1  high from frame completion until the next accepted `start`.
- `out_rd_addr`  in  11  output pixel index, `r*40 + c`.
- `out_rd_data`  out  8  registered `memoria_saida[out_rd_addr]`; one-cycle read latency; valid at any time.

## Operation
- FSM states: IDLE, FETCH, WRITE, DONE.
- IDLE: `busy=0`. On `start`: clear the block counters (bx=0, by=0) and the in-block counters (i=0, j=0), clear the accumulator, then go to FETCH.
- FETCH: each cycle, present `in_addr = (by*FACTOR+j)*W_IN + bx*FACTOR + i`. Scan the block row by row: i is the inner counter, j the outer.
  - The accumulator adds `in_data` each cycle starting from the cycle after the first address.
  - After the FACTOR² addresses have been issued, go to WRITE.
- WRITE: add the last `in_data`, then write `(acc + in_data) >> log2(FACTOR²)` to `memoria_saida[by*40+bx]`. The result is truncated, not rounded. Clear the accumulator.
  - Advance bx; on wrap from 39 to 0, advance by.
  - If the block just written was bx=39, by=29, go to DONE; otherwise go to FETCH.
- DONE: set `done=1` and `busy=0`, then go to IDLE. `done` stays high until the next accepted `start`, which clears it in the same cycle.
- Accumulator width is 12 bits (16×255 = 4080), so no overflow is possible.
- `memoria_saida` is 1200×8. It is not cleared by reset and keeps its contents across frames, resets and aborts.
- Reset mid-frame: abort immediately and return to IDLE. Blocks already written stay written; no further writes occur.
- `start` while `busy`: ignored. A new frame fully overwrites `memoria_saida`.

## Timing
- Reset values: `busy=0`, `done=0`, `in_addr=0`, `out_rd_data=0`, state IDLE.
- `start` sampled high in IDLE: the first `in_addr` appears the next cycle and `busy` rises that cycle.
- Per block: FACTOR² FETCH cycles plus 1 WRITE cycle, giving 17 cycles with FACTOR=4.
- Full frame: 1200 × 17 = 20400 cycles from the first FETCH to the last WRITE. `done` rises one cycle after the last WRITE.
- `memoria_saida[k]` is readable via `out_rd_data` one cycle after the WRITE cycle of block k.
- `in_addr` is held at its last value outside FETCH.

## Test plan
- Constant input 0x80 everywhere, one `start` → all 1200 outputs = 0x80; `done` high exactly 20401 cycles after `start` was sampled.
- Input pixel = `y` (row index) → `out[r*40+c]` = `(16r+6)*4/4 >> 2`, i.e. `4r+1` (mean of 4r..4r+3, truncated). Examples: out[0]=0x01, out[1199]=0x75.
- Truncation: block (0,0) has fifteen 0x00 and one 0x0F, all else 0xFF → out[0]=0x00, out[1]=0xFF.
- Saturated: all 0xFF → all outputs 0xFF with no overflow; checkerboard 0x00/0xFF per pixel → all outputs 0x7F.
- `rst_n` asserted at cycle 500 of a frame → `busy`=`done`=0 immediately, `in_addr`=0. out[0..28] hold the new values; the remaining entries hold old contents.
- `start` pulsed again mid-frame → no restart; completion cycle unchanged. A second frame after `done` → `done` clears and all outputs are overwritten.
